// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: arbitrates LLC input channels and queues {channel, set, tag} for set lookup
module llc_input_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 26,
    parameter int SET_W        = 10,
    parameter int DEPTH        = 2,
    parameter int RR_EN        = 0,
    parameter int STARVE_LIMIT = 15,
    localparam int CH_W        = NUM_CH > 2 ? $clog2(NUM_CH) : 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*ADDR_W-1:0]   in_addr,
    input  logic [NUM_CH-1:0]          in_block,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic [SET_W-1:0]           out_set,
    output logic [ADDR_W-SET_W-1:0]    out_tag,
    output logic [CNT_W-1:0]           count,
    output logic                       idle
);
    localparam int TAG_W = ADDR_W - SET_W;
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] starved;
    logic [NUM_CH-1:0] gnt;
    logic [7:0]        wait_q [NUM_CH];
    logic [7:0]        wait_d [NUM_CH];
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   rr_d;
    logic [CH_W-1:0]   win;
    logic [CH_W:0]     cand;
    logic [ADDR_W-1:0] win_addr;
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  wr_d;
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  rd_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CH_W-1:0]   ch_mem  [DEPTH];
    logic [SET_W-1:0]  set_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic              pop;
    logic              push;
    logic              can_push;

    assign elig      = in_valid & ~in_block;
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    assign can_push  = (count_q != CNT_W'(DEPTH)) | pop;
    assign push      = can_push & (|elig);
    assign gnt       = push ? NUM_CH'(1) << win : '0;
    assign in_ready  = gnt;
    assign count     = count_q;
    assign idle      = ~(|elig) & ~out_valid;
    assign out_ch    = ch_mem[rd_q];
    assign out_set   = set_mem[rd_q];
    assign out_tag   = tag_mem[rd_q];

    // a channel is starved once its wait count has saturated while it is still eligible
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) starved[i] = elig[i] & (wait_q[i] == LIMIT);
    end

    // winner: lowest starved channel, else lowest eligible (fixed) or first eligible after rr_q
    always_comb begin
        win  = '0;
        cand = '0;
        if (|starved) begin
            for (int i = NUM_CH - 1; i >= 0; i--) if (starved[i]) win = CH_W'(i);
        end else if (RR_EN == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) if (elig[i]) win = CH_W'(i);
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = {1'b0, rr_q} + (CH_W + 1)'(k);
                cand = cand >= (CH_W + 1)'(NUM_CH) ? cand - (CH_W + 1)'(NUM_CH) : cand;
                if (elig[cand[CH_W-1:0]]) win = cand[CH_W-1:0];
            end
        end
    end

    // select the winning channel's line address
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_CH; i++) if (CH_W'(i) == win) win_addr = in_addr[i*ADDR_W +: ADDR_W];
    end

    // wait counters clear on grant or absence, hold while blocked, count up while losing
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wait_d[i] = (!in_valid[i] || gnt[i]) ? 8'd0 :
                        (elig[i] && wait_q[i] != LIMIT) ? wait_q[i] + 8'd1 : wait_q[i];
        end
    end

    // pointer and occupancy next state
    always_comb begin
        rr_d    = push ? win : rr_q;
        wr_d    = push ? (wr_q == PTR_W'(DEPTH - 1) ? '0 : wr_q + PTR_W'(1)) : wr_q;
        rd_d    = pop ? (rd_q == PTR_W'(DEPTH - 1) ? '0 : rd_q + PTR_W'(1)) : rd_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // control state; reset drops every queued entry at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) wait_q[i] <= '0;
            rr_q    <= CH_W'(NUM_CH - 1);
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) wait_q[i] <= wait_d[i];
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // queue storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (push) begin
            ch_mem[wr_q]  <= win;
            set_mem[wr_q] <= win_addr[SET_W-1:0];
            tag_mem[wr_q] <= win_addr[ADDR_W-1:SET_W];
        end
    end
endmodule

// File: tb/tb_llc_input_arbiter.sv
// tb_llc_input_arbiter: fixed-priority and round-robin instances checked against a queue-based model
module tb_llc_input_arbiter;
    localparam int N  = 4;
    localparam int AW = 26;
    localparam int SW = 10;
    localparam int TW = AW - SW;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_block;
    logic [N*AW-1:0] in_addr;
    logic            out_ready;
    logic [N-1:0]    rdy  [2];
    logic            ov   [2];
    logic [1:0]      och  [2];
    logic [SW-1:0]   oset [2];
    logic [TW-1:0]   otag [2];
    logic [1:0]      cnt  [2];
    logic            idl  [2];

    int checks = 0;
    int errors = 0;
    int wt [2][N];
    int rr [2];
    int mq [2][$];

    always #5 clk = ~clk;

    llc_input_arbiter #(.NUM_CH(N), .ADDR_W(AW), .SET_W(SW), .DEPTH(D), .RR_EN(0), .STARVE_LIMIT(3)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_block(in_block),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_ch(och[0]),
        .out_set(oset[0]), .out_tag(otag[0]), .count(cnt[0]), .idle(idl[0]));

    llc_input_arbiter #(.NUM_CH(N), .ADDR_W(AW), .SET_W(SW), .DEPTH(D), .RR_EN(1), .STARVE_LIMIT(15)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_block(in_block),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_ch(och[1]),
        .out_set(oset[1]), .out_tag(otag[1]), .count(cnt[1]), .idle(idl[1]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int k);
        return k == 0 ? 3 : 15;
    endfunction

    function automatic bit is_elig(input int i);
        return in_valid[i] && !in_block[i];
    endfunction

    function automatic int addr_of(input int ch);
        logic [AW-1:0] a;
        a = in_addr[ch*AW +: AW];
        return int'(a);
    endfunction

    function automatic int exp_grant(input int k);
        bit can_push;
        can_push = mq[k].size() < D || (mq[k].size() > 0 && out_ready);
        if (!can_push) return -1;
        for (int i = 0; i < N; i++) if (is_elig(i) && wt[k][i] == lim(k)) return i;
        if (k == 0) begin
            for (int i = 0; i < N; i++) if (is_elig(i)) return i;
        end else begin
            for (int s = 1; s <= N; s++) if (is_elig((rr[k] + s) % N)) return (rr[k] + s) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        int h;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                chk($sformatf("rst_out_valid%0d", k), int'(ov[k]), 0);
                chk($sformatf("rst_count%0d", k), int'(cnt[k]), 0);
                mq[k].delete();
                rr[k] = N - 1;
                for (int i = 0; i < N; i++) wt[k][i] = 0;
            end else begin
                g = exp_grant(k);
                chk($sformatf("in_ready%0d", k), int'(rdy[k]), g < 0 ? 0 : (1 << g));
                chk($sformatf("count%0d", k), int'(cnt[k]), mq[k].size());
                chk($sformatf("out_valid%0d", k), int'(ov[k]), int'(mq[k].size() > 0));
                chk($sformatf("idle%0d", k), int'(idl[k]), int'((in_valid & ~in_block) == 0 && mq[k].size() == 0));
                if (mq[k].size() > 0) begin
                    h = mq[k][0];
                    chk($sformatf("out_ch%0d", k), int'(och[k]), h >> AW);
                    chk($sformatf("out_set%0d", k), int'(oset[k]), (h % (1 << AW)) % (1 << SW));
                    chk($sformatf("out_tag%0d", k), int'(otag[k]), (h % (1 << AW)) >> SW);
                end
                if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
                if (g >= 0) begin
                    mq[k].push_back((g << AW) | addr_of(g));
                    rr[k] = g;
                end
                for (int i = 0; i < N; i++) begin
                    if (g == i || !in_valid[i]) wt[k][i] = 0;
                    else if (is_elig(i)) wt[k][i] = wt[k][i] < lim(k) ? wt[k][i] + 1 : lim(k);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = '0;
        in_block  = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        in_addr = '0;
        in_addr[0*AW +: AW] = 26'h1234567;
        in_addr[1*AW +: AW] = 26'h0ABC123;
        in_addr[2*AW +: AW] = 26'h3FFFFFF;
        in_addr[3*AW +: AW] = 26'h0000400;
        do_reset;

        // fixed priority and address split
        in_valid  = 4'b1110;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready", int'(rdy[0]), 4'b0010);
        step;
        in_valid = '0;
        @(negedge clk);
        chk("t1_valid", int'(ov[0]), 1);
        chk("t1_ch", int'(och[0]), 1);
        chk("t1_set", int'(oset[0]), 'h123);
        chk("t1_tag", int'(otag[0]), 'h2AF0);
        step;

        // round robin order
        do_reset;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t2_grant%0d", c), int'(rdy[1]), 1 << order[c]);
            if (c > 0) chk($sformatf("t2_count%0d", c), int'(cnt[1]), 1);
            step;
        end

        // full queue
        do_reset;
        in_valid = 4'b0001;
        @(negedge clk);
        chk("t3_g0", int'(rdy[0]), 1);
        step;
        @(negedge clk);
        chk("t3_g1", int'(rdy[0]), 1);
        chk("t3_c1", int'(cnt[0]), 1);
        step;
        @(negedge clk);
        chk("t3_full_ready", int'(rdy[0]), 0);
        chk("t3_full_count", int'(cnt[0]), 2);
        step;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_pp_ready", int'(rdy[0]), 1);
        chk("t3_pp_count", int'(cnt[0]), 2);
        step;
        @(negedge clk);
        chk("t3_pp_count2", int'(cnt[0]), 2);
        step;

        // starvation promotion
        do_reset;
        in_valid  = 4'b0101;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4_grant%0d", c), int'(rdy[0]), c == 3 ? 4'b0100 : 4'b0001);
            step;
        end

        // blocking: blocked channels are skipped and their wait counters hold
        do_reset;
        in_valid  = 4'b0101;
        in_block  = 4'b0001;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t5_grant%0d", c), int'(rdy[0]), 4'b0100);
            step;
        end
        in_block = '0;
        @(negedge clk);
        chk("t5_unblock", int'(rdy[0]), 4'b0001);
        step;
        in_valid = 4'b0110;
        in_block = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t5b_grant%0d", c), int'(rdy[0]), 4'b0010);
            step;
        end
        in_block = '0;
        @(negedge clk);
        chk("t5b_hold", int'(rdy[0]), 4'b0010);
        step;

        // reset mid-operation
        do_reset;
        in_valid = 4'b0001;
        step;
        step;
        in_valid = '0;
        @(negedge clk);
        chk("t6_count_pre", int'(cnt[0]), 2);
        chk("t6_valid_pre", int'(ov[0]), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_valid0", int'(ov[0]), 0);
        chk("t6_count0", int'(cnt[0]), 0);
        chk("t6_valid1", int'(ov[1]), 0);
        chk("t6_count1", int'(cnt[1]), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_idle0", int'(idl[0]), 1);
        chk("t6_idle1", int'(idl[1]), 1);
        step;

        // mixed traffic against the model
        for (int c = 0; c < 200; c++) begin
            in_valid  = N'($urandom);
            in_block  = N'($urandom & $urandom);
            out_ready = $urandom_range(0, 3) != 0;
            in_addr[($urandom_range(0, N - 1))*AW +: AW] = AW'($urandom);
            step;
        end
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (4) step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
